// File: rtl/pcre_engine_pkg.sv
// Shared definitions for the PCRE chain matcher: anchor modes, control FSM encoding
// and a small constant-width helper.
package pcre_engine_pkg;

    localparam int ANCHOR_NONE = 0;
    localparam int ANCHOR_SOD  = 1;
    localparam int ANCHOR_SOL  = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } fsm_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pcre_state_cell.sv
// One NFA state of the linear chain: active when its class hits and it is reached from
// the predecessor, from itself (loop) or from two states back (skip).
module pcre_state_cell #(
    parameter bit LOOP = 1'b0,
    parameter bit SKIP = 1'b0
) (
    input  logic clk,
    input  logic sod,
    input  logic ce,
    input  logic cls_hit,
    input  logic prev,
    input  logic prev2,
    output logic state
);

    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            state <= 1'b0;
        end else if (ce) begin
            state <= cls_hit & (prev | (LOOP & state) | (SKIP & prev2));
        end
    end

endmodule

// File: rtl/pcre_chain_engine.sv
// Linear-NFA matcher over the one-hot character-class bus with sticky match,
// first-match position capture and a per-packet valid/ready result.
module pcre_chain_engine
    import pcre_engine_pkg::*;
#(
    parameter int                          N_CLASS   = 40,
    parameter int                          N_STATES  = 12,
    parameter int                          CLS_W     = 6,
    parameter logic [N_STATES*CLS_W-1:0]   CLASS_SEL = '0,
    parameter logic [N_STATES-1:0]         LOOP_MASK = '0,
    parameter logic [N_STATES-1:0]         SKIP_MASK = '0,
    parameter int                          ANCHOR    = 0,
    parameter int                          NL_IDX    = 0,
    parameter int                          POS_W     = 16
) (
    input  logic               clk,
    input  logic               sod,
    input  logic               en,
    input  logic [N_CLASS-1:0] in_class,
    input  logic               eod,
    output logic               match,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_match,
    output logic [POS_W-1:0]   res_pos
);

    fsm_state_t       state_q, state_d;
    logic             drain_cnt_q;
    logic             step;
    logic             start_tok;
    logic             first_q, nl_q, match_q;
    logic [POS_W-1:0] pos_q, pos_d_p1, fpos_q;
    // chain[0] is the empty s[-1], chain[1] the start token, chain[i+1] is state i
    logic [N_STATES+1:0] chain;

    assign step = en && (state_q == ST_RUN);

    always_comb begin
        case (ANCHOR)
            ANCHOR_SOD: start_tok = first_q;
            ANCHOR_SOL: start_tok = first_q | nl_q;
            default:    start_tok = 1'b1;
        endcase
    end

    assign chain[0] = 1'b0;
    assign chain[1] = start_tok;

    // ---- stage p0 -> p1: state chain, advanced once per accepted byte
    for (genvar i = 1; i <= N_STATES; i++) begin : g_cell
        logic [CLS_W-1:0] sel;
        assign sel = CLASS_SEL[(i-1)*CLS_W +: CLS_W];

        pcre_state_cell #(
            .LOOP (LOOP_MASK[i-1]),
            .SKIP ((i > 1) ? SKIP_MASK[i-1] : 1'b0)
        ) u_cell (
            .clk     (clk),
            .sod     (sod),
            .ce      (step),
            .cls_hit (in_class[sel]),
            .prev    (chain[i]),
            .prev2   (chain[i-1]),
            .state   (chain[i+1])
        );
    end

    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            first_q  <= 1'b1;
            nl_q     <= 1'b0;
            pos_q    <= '0;
            pos_d_p1 <= '0;
        end else if (step) begin
            first_q  <= 1'b0;
            nl_q     <= in_class[NL_IDX];
            pos_d_p1 <= pos_q;
            if (pos_q != {POS_W{1'b1}}) pos_q <= pos_q + 1'b1;
        end
    end

    // ---- stage p1 -> p2: sticky match and first-match position, free-running
    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            match_q <= 1'b0;
            fpos_q  <= '0;
        end else begin
            match_q <= match_q | chain[N_STATES+1];
            if (chain[N_STATES+1] && !match_q) fpos_q <= pos_d_p1;
        end
    end

    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= (state_q == ST_DRAIN) && !drain_cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (eod) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt_q) state_d = ST_REPORT;
            ST_REPORT: if (res_ready) state_d = ST_DONE;
            default:   state_d = state_q;
        endcase
    end

    always_comb begin
        res_valid = (state_q == ST_REPORT);
        res_match = res_valid & match_q;
        res_pos   = res_valid ? fpos_q : '0;
        match     = match_q;
    end

endmodule

// File: tb/tb_pcre_chain_engine.sv
// Bench for the "ab+c" family of chains: five configurations share one stimulus stream
// and are compared against a start/end enumerating reference matcher.
module tb_pcre_chain_engine;

    localparam int NU = 5;
    localparam int NC = 8;
    localparam int NS = 3;
    localparam int CW = 3;
    localparam logic [NS*CW-1:0] SEL = {3'd2, 3'd1, 3'd0};

    localparam logic [NC-1:0] SYM_A  = 8'h01;
    localparam logic [NC-1:0] SYM_B  = 8'h02;
    localparam logic [NC-1:0] SYM_C  = 8'h04;
    localparam logic [NC-1:0] SYM_NL = 8'h08;
    localparam logic [NC-1:0] SYM_X  = 8'h10;

    logic          clk = 1'b0;
    logic          sod = 1'b0;
    logic          en = 1'b0;
    logic          eod = 1'b0;
    logic          res_ready = 1'b0;
    logic [NC-1:0] in_class = '0;
    logic [NU-1:0] match, res_valid, res_match;
    logic [15:0]   pos0, pos1, pos2, pos3;
    logic [3:0]    pos4;

    int          anc  [NU] = '{0, 1, 2, 0, 0};
    logic [2:0]  lm   [NU] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b010};
    logic [2:0]  sm   [NU] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
    int          pmax [NU] = '{65535, 65535, 65535, 65535, 15};

    logic [NC-1:0] pkt[$];
    int  checks = 0;
    int  errors = 0;
    logic        got_match [NU];
    logic [31:0] got_pos   [NU];
    logic [NU-1:0] m_lat0, m_lat1;

    always #5 clk = ~clk;

    pcre_chain_engine #(.N_CLASS(NC), .N_STATES(NS), .CLS_W(CW), .CLASS_SEL(SEL),
        .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR(0), .NL_IDX(3), .POS_W(16)) u0 (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod), .match(match[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready), .res_match(res_match[0]), .res_pos(pos0));
    pcre_chain_engine #(.N_CLASS(NC), .N_STATES(NS), .CLS_W(CW), .CLASS_SEL(SEL),
        .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR(1), .NL_IDX(3), .POS_W(16)) u1 (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod), .match(match[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready), .res_match(res_match[1]), .res_pos(pos1));
    pcre_chain_engine #(.N_CLASS(NC), .N_STATES(NS), .CLS_W(CW), .CLASS_SEL(SEL),
        .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR(2), .NL_IDX(3), .POS_W(16)) u2 (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod), .match(match[2]),
        .res_valid(res_valid[2]), .res_ready(res_ready), .res_match(res_match[2]), .res_pos(pos2));
    pcre_chain_engine #(.N_CLASS(NC), .N_STATES(NS), .CLS_W(CW), .CLASS_SEL(SEL),
        .LOOP_MASK(3'b000), .SKIP_MASK(3'b100), .ANCHOR(0), .NL_IDX(3), .POS_W(16)) u3 (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod), .match(match[3]),
        .res_valid(res_valid[3]), .res_ready(res_ready), .res_match(res_match[3]), .res_pos(pos3));
    pcre_chain_engine #(.N_CLASS(NC), .N_STATES(NS), .CLS_W(CW), .CLASS_SEL(SEL),
        .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR(0), .NL_IDX(3), .POS_W(4)) u4 (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod), .match(match[4]),
        .res_valid(res_valid[4]), .res_ready(res_ready), .res_match(res_match[4]), .res_pos(pos4));

    function automatic logic [31:0] get_pos(input int u);
        case (u)
            0:       return {16'h0, pos0};
            1:       return {16'h0, pos1};
            2:       return {16'h0, pos2};
            3:       return {16'h0, pos3};
            default: return {28'h0, pos4};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a match ends at byte j if some legal start k lets the element
    // sequence consume exactly bytes k..j.
    function automatic bit start_ok(input int u, input int k);
        if (anc[u] == 1) return k == 0;
        if (anc[u] == 2) return (k == 0) || pkt[k-1][3];
        return 1'b1;
    endfunction

    function automatic bit seg_end(input int u, input int k, input int j);
        bit act [NS+1];
        bit nxt [NS+1];
        for (int e = 0; e <= NS; e++) act[e] = 1'b0;
        act[1] = pkt[k][0];
        act[2] = sm[u][1] && pkt[k][1];
        for (int b = k + 1; b <= j; b++) begin
            nxt[0] = 1'b0;
            for (int e = 1; e <= NS; e++)
                nxt[e] = pkt[b][e-1] && ((e > 1 && act[e-1]) || (lm[u][e-1] && act[e]) ||
                                         (e > 2 && sm[u][e-1] && act[e-2]));
            act = nxt;
        end
        return act[NS];
    endfunction

    task automatic expect_result(input int u, output bit em, output int ep);
        em = 1'b0;
        ep = 0;
        for (int j = 0; j < pkt.size() && !em; j++)
            for (int k = 0; k <= j && !em; k++)
                if (start_ok(u, k) && seg_end(u, k, j)) begin
                    em = 1'b1;
                    ep = (j > pmax[u]) ? pmax[u] : j;
                end
    endtask

    task automatic load(input string s);
        pkt.delete();
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "a":     pkt.push_back(SYM_A);
                "b":     pkt.push_back(SYM_B);
                "c":     pkt.push_back(SYM_C);
                "\n":    pkt.push_back(SYM_NL);
                default: pkt.push_back(SYM_X);
            endcase
        end
    endtask

    function automatic logic [NC-1:0] rand_sym();
        case ($urandom_range(0, 7))
            0, 1:    return SYM_A;
            2, 3:    return SYM_B;
            4:       return SYM_C;
            5:       return SYM_NL;
            6:       return SYM_X;
            default: return NC'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; eod = 1'b0; res_ready = 1'b0;
        sod = 1'b1;
        #1;
        check("rst_match", 32'(match), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_match", 32'(res_match), 0);
        check("rst_res_pos", get_pos(0) | get_pos(4), 0);
        @(negedge clk);
        sod = 1'b0;
    endtask

    task automatic run_packet(input int ready_delay, input bit gaps);
        bit            em;
        int            ep;
        logic [NU-1:0] exp_m;
        logic [31:0]   held_pos;
        do_reset();
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    en = 1'b0; eod = 1'b0; in_class = NC'($urandom);
                    @(negedge clk);
                end
            end
            en = 1'b1; in_class = pkt[i]; eod = (i == pkt.size() - 1);
            @(negedge clk);
        end
        en = 1'b0; eod = 1'b0; in_class = '0;
        m_lat0 = match;
        @(negedge clk);
        m_lat1 = match;
        @(negedge clk);
        check("res_valid_latency", 32'(res_valid), 32'({NU{1'b1}}));
        for (int u = 0; u < NU; u++) begin
            expect_result(u, em, ep);
            exp_m[u] = em;
            got_match[u] = res_match[u];
            got_pos[u] = get_pos(u);
            check($sformatf("res_match_u%0d", u), 32'(res_match[u]), 32'(em));
            check($sformatf("res_pos_u%0d", u), get_pos(u), 32'(ep));
            check($sformatf("live_match_u%0d", u), 32'(match[u]), 32'(em));
        end
        held_pos = get_pos(0);
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'({NU{1'b1}}));
            check("hold_pos", get_pos(0), held_pos);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("done_valid", 32'(res_valid), 0);
        for (int d = 0; d < 3; d++) begin
            en = 1'b1; eod = 1'b1; in_class = SYM_A | SYM_B | SYM_C;
            @(negedge clk);
        end
        en = 1'b0; eod = 1'b0; in_class = '0;
        @(negedge clk);
        @(negedge clk);
        check("done_match_kept", 32'(match), 32'(exp_m));
        check("done_valid_low", 32'(res_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // 1: unanchored "ab+c", match latency and position
        load("xabbbc");
        run_packet(0, 1'b0);
        check("t1_lat_p0", 32'(m_lat0[0]), 0);
        check("t1_lat_p1", 32'(m_lat1[0]), 1);
        check("t1_match", 32'(got_match[0]), 1);
        check("t1_pos", got_pos[0], 5);
        // 2: start-of-data anchor
        check("t2_sod_nomatch", 32'(got_match[1]), 0);
        check("t2_sod_pos0", got_pos[1], 0);
        load("abc");
        run_packet(1, 1'b0);
        check("t2_sod_match", 32'(got_match[1]), 1);
        check("t2_sod_pos", got_pos[1], 2);
        // 3: start-of-line anchor
        load("x\nabbc");
        run_packet(0, 1'b0);
        check("t3_sol_match", 32'(got_match[2]), 1);
        check("t3_sol_pos", got_pos[2], 5);
        load("xabc");
        run_packet(0, 1'b0);
        check("t3_sol_nomatch", 32'(got_match[2]), 0);
        // 4: optional middle element
        load("zac");
        run_packet(0, 1'b0);
        check("t4_skip_match", 32'(got_match[3]), 1);
        check("t4_skip_pos", got_pos[3], 2);
        load("abbc");
        run_packet(0, 1'b0);
        check("t4_skip_nomatch", 32'(got_match[3]), 0);
        // 5: result held under backpressure, then abort mid-packet
        load("abcc");
        run_packet(6, 1'b1);
        do_reset();
        load("abcx");
        for (int i = 0; i < pkt.size(); i++) begin
            en = 1'b1; in_class = pkt[i];
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        check("t5_pre_abort_match", 32'(match[0]), 1);
        sod = 1'b1;
        #1;
        check("t5_abort_match", 32'(match), 0);
        check("t5_abort_valid", 32'(res_valid | res_match), 0);
        check("t5_abort_pos", get_pos(0) | get_pos(4), 0);
        @(negedge clk);
        sod = 1'b0;
        // 6: saturating position and first-match retention
        pkt.delete();
        for (int i = 0; i < 20; i++) pkt.push_back(SYM_X);
        pkt.push_back(SYM_A); pkt.push_back(SYM_B); pkt.push_back(SYM_C);
        run_packet(0, 1'b0);
        check("t6_sat_pos", got_pos[4], 15);
        load("abcabc");
        run_packet(0, 1'b0);
        check("t6_first_pos", got_pos[4], 2);
        // randomized packets against the reference
        for (int n = 0; n < 40; n++) begin
            int len;
            len = $urandom_range(1, 20);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(rand_sym());
            run_packet($urandom_range(0, 3), 1'b1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
